spike_network: RTL
==================

# spike_network

Collects the 2-bit spike outputs of all active neurons once every neuron has raised its network request. It picks exactly one firing neuron per round with a round-robin arbiter. It then broadcasts `{spike, neuron_id}` on the shared spike bus and pulses `networkDone`. It is the network end of the neuron's `en_network` / `networkDone` / `spike_in` protocol and sits between the neuron array and the top-level controller.

## Interface
Parameters:
- `TEN_DATA_WIDTH`, 2: spike code width (0 none, 1 positive, 2 negative, 3 illegal).
- `NEURON_ID_WIDTH`, 8: neuron index width.
- `NUM_NEURON`, 256: number of neuron request/spike lanes.

Ports:
- `clk`  in  1  block clock; one clock for the whole block.
- `reset_l`  in  1  asynchronous, active-low reset.
- `en_net`  in  1  global enable; when low, all registers hold.
- `active_neuron`  in  NEURON_ID_WIDTH  number of participating neurons (lanes 0..active_neuron-1).
- `en_network`  in  NUM_NEURON  per-neuron round request.
- `spike_out`  in  NUM_NEURON*TEN_DATA_WIDTH  per-neuron spike code; lane i is bits [2i+1:2i].
- `spike_in`  out  TEN_DATA_WIDTH+NEURON_ID_WIDTH  broadcast `{spike, id}`; reset value 0.
- `networkDone`  out  1  one-cycle round-complete pulse; reset value 0.
- `spike_err`  out  1  sticky flag, set when an illegal code (3) is sampled; reset value 0.

## Operation
- The FSM has four states: IDLE, COLLECT, SCAN, DONE. Reset enters IDLE.
- IDLE:
  - If `active_neuron` ≠ 0, go to COLLECT.
  - If `active_neuron` = 0, stay in IDLE and never pulse `networkDone`.
- COLLECT:
  - Waits until `en_network[i]` = 1 for every i < active_neuron; lanes ≥ active_neuron are ignored.
  - On that cycle, snapshot all spike lanes into a register and load `ptr` = `start_ptr`, then go to SCAN.
- SCAN examines `snap[ptr]`, one lane per cycle:
  - Code 1 or 2: register `spike_in` = {code, ptr} and `start_ptr` = ptr+1 (wrapping to 0 at active_neuron). Go to DONE.
  - Code 0 or 3: advance `ptr` with wrap. Code 3 also sets `spike_err`.
  - After active_neuron lanes with no hit: register `spike_in` = 0, leave `start_ptr` unchanged, and go to DONE.
- DONE: `networkDone` = 1 for exactly this cycle, then go to COLLECT.
- `spike_in` is held stable from DONE until the next DONE.
- Neurons drop `en_network` combinationally during `networkDone` and stay low for several cycles, so a stale round cannot re-trigger COLLECT.
- Any `en_network` lane dropping during SCAN or DONE is ignored, because the snapshot is authoritative.
- A change to `active_neuron` is sampled only at COLLECT entry to SCAN.
- The scan counter is NEURON_ID_WIDTH+1 bits wide so that a count of active_neuron can be represented.
- `spike_err` is cleared only by reset.

## Timing
- `networkDone` is registered: it is high in the cycle after the SCAN hit.
- Latency from the COLLECT condition being met to `networkDone`:
  - 2 cycles when the lane at `start_ptr` fires.
  - k+2 cycles when the winner is k lanes after `start_ptr`.
  - active_neuron+1 cycles when no lane fires.
- The neuron samples `spike_in` in the cycle after `networkDone`, so `spike_in` must be valid no later than the `networkDone` cycle.
- With `en_net` low, the state, `ptr`, snapshot and outputs all freeze; a `networkDone` that is high stays high until `en_net` returns.
- Asserting `reset_l` low mid-round immediately clears all outputs and returns to IDLE; no partial round completes.

## Configuration
- Macro: `SPIKE_LFSR_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances once per DONE.
  - At each COLLECT→SCAN transition, `start_ptr` = lfsr[NEURON_ID_WIDTH-1:0] if that value is < active_neuron, else 0.
  - The round-robin update of `start_ptr` is disabled.
- Undefined: pure round-robin as described above; no LFSR logic is compiled.

## Structure
- Shared package `neurosa_pkg`:
  - spike code constants `SPK_NONE=0`, `SPK_POS=1`, `SPK_NEG=2`;
  - FSM state encoding;
  - LFSR seed and taps.
- Natural sub-module: `spike_rr_scan`, holding the `ptr` / wrap / count logic and exposing `hit`, `win_id` and `exhausted`.

## Test plan
- Reset: active_neuron=4, all requests high, lane 2 = 1 → first pulse has `spike_in` = {1, 2}, reached in 4 cycles after COLLECT entry (start_ptr 0, lanes 0–1 empty).
- Round robin: lanes 1 and 3 both = 2 on consecutive rounds → winners are 1, then 3, then 1; `start_ptr` wraps at 4.
- No spikes: active_neuron=5, all lanes 0 → `spike_in` = 0 and `networkDone` arrives 6 cycles after COLLECT; `start_ptr` unchanged.
- Partial requests: lane 3 request held low for 10 cycles → no `networkDone` until it rises; a request on lane 7 (outside active_neuron=4) has no effect.
- Illegal code: lane 0 = 3, lane 1 = 1 → winner is 1 and `spike_err` = 1 and stays set.
- Reset mid-SCAN, then `en_net` low during DONE → outputs clear to 0 on reset; `networkDone` stays held while `en_net` is low, then drops one cycle after `en_net` returns.

Source files
------------

// File: rtl/neurosa_pkg.sv
// Shared definitions for the neuron/network slice: spike codes, the
// network FSM state encoding and the optional start-pointer LFSR constants.
package neurosa_pkg;

  localparam logic [1:0] SPK_NONE = 2'd0;
  localparam logic [1:0] SPK_POS  = 2'd1;
  localparam logic [1:0] SPK_NEG  = 2'd2;
  localparam logic [1:0] SPK_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Fibonacci LFSR, taps at bit positions 16,14,13,11 (1-based).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spike_rr_scan.sv
// Round-robin lane scanner: walks the spike snapshot one lane per cycle from
// a start pointer, wrapping at the participating lane count, and reports the
// first positive/negative spike (hit) or that every lane was visited (exhausted).
module spike_rr_scan
  import neurosa_pkg::*;
#(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int NUM_NEURON      = 256
) (
  input  logic                                 clk,
  input  logic                                 reset_l,
  input  logic                                 en_i,
  input  logic                                 load_i,
  input  logic                                 scan_i,
  input  logic [NEURON_ID_WIDTH-1:0]           start_ptr_i,
  input  logic [NEURON_ID_WIDTH-1:0]           active_i,
  input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0] snap_i,
  output logic                                 hit_o,
  output logic                                 exhausted_o,
  output logic                                 illegal_o,
  output logic [NEURON_ID_WIDTH-1:0]           win_id_o,
  output logic [NEURON_ID_WIDTH-1:0]           next_ptr_o,
  output logic [TEN_DATA_WIDTH-1:0]            win_code_o
);

  logic [NEURON_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NEURON_ID_WIDTH:0]   cnt_q, cnt_d;
  logic [NEURON_ID_WIDTH-1:0] active_q, active_d;

  logic [TEN_DATA_WIDTH-1:0]  lanes [NUM_NEURON];
  logic [TEN_DATA_WIDTH-1:0]  laneCode;
  logic [NEURON_ID_WIDTH:0]   ptrInc;
  logic [NEURON_ID_WIDTH:0]   cntInc;
  logic [NEURON_ID_WIDTH-1:0] ptrWrapped;
  logic [NEURON_ID_WIDTH-1:0] startClamp;
  logic                       isSpike;

  for (genvar g = 0; g < NUM_NEURON; g++) begin : gLane
    assign lanes[g] = snap_i[g*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
  end

  // Decode the current lane, compute the wrapped successor and the next scan position.
  always_comb begin
    laneCode    = lanes[ptr_q];
    isSpike     = (laneCode == SPK_POS) || (laneCode == SPK_NEG);
    ptrInc      = {1'b0, ptr_q} + 1'b1;
    cntInc      = cnt_q + 1'b1;
    ptrWrapped  = (ptrInc >= {1'b0, active_q}) ? '0 : ptrInc[NEURON_ID_WIDTH-1:0];
    startClamp  = (start_ptr_i < active_i) ? start_ptr_i : '0;
    hit_o       = scan_i && isSpike;
    exhausted_o = scan_i && !isSpike && (cntInc >= {1'b0, active_q});
    illegal_o   = scan_i && (laneCode == SPK_ILL);
    win_id_o    = ptr_q;
    win_code_o  = laneCode;
    next_ptr_o  = ptrWrapped;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    if (load_i) begin
      ptr_d    = startClamp;
      cnt_d    = '0;
      active_d = active_i;
    end else if (scan_i && !isSpike) begin
      ptr_d = ptrWrapped;
      cnt_d = cntInc;
    end
  end

  // Scan pointer, visited-lane count and the lane count latched for this round.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      active_q <= '0;
    end else if (en_i) begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/spike_network.sv
// Network end of the neuron en_network/networkDone/spike_in handshake.
// Waits for all active neurons to request, snapshots their spike codes,
// picks one firing neuron round-robin and broadcasts {spike, id}.
// Optional macro SPIKE_LFSR_EN replaces the round-robin start pointer with
// an LFSR-derived one.
module spike_network
  import neurosa_pkg::*;
#(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int NUM_NEURON      = 256
) (
  input  logic                                      clk,
  input  logic                                      reset_l,
  input  logic                                      en_net,
  input  logic [NEURON_ID_WIDTH-1:0]                active_neuron,
  input  logic [NUM_NEURON-1:0]                     en_network,
  input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]      spike_out,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
  output logic                                      networkDone,
  output logic                                      spike_err
);

  state_e state_q, state_d;

  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]      snap_q;
  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in_q;
  logic                                      networkDone_q;
  logic                                      spike_err_q;

  logic                       reqAll;
  logic                       load;
  logic                       scan;
  logic                       hit;
  logic                       exhausted;
  logic                       illegal;
  logic [NEURON_ID_WIDTH-1:0] winId;
  logic [NEURON_ID_WIDTH-1:0] nextPtr;
  logic [TEN_DATA_WIDTH-1:0]  winCode;
  logic [NEURON_ID_WIDTH-1:0] startSel;

`ifdef SPIKE_LFSR_EN
  logic [15:0] lfsr_q;

  // Random start lane: LFSR low bits when they name a participating lane, else lane 0.
  always_comb begin
    startSel = '0;
    if (lfsr_q[NEURON_ID_WIDTH-1:0] < active_neuron) begin
      startSel = lfsr_q[NEURON_ID_WIDTH-1:0];
    end
  end

  // LFSR steps once per completed round.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_net && (state_q == ST_DONE)) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  logic unusedNextPtr;
  assign unusedNextPtr = ^nextPtr;
`else
  logic [NEURON_ID_WIDTH-1:0] start_ptr_q;

  assign startSel = start_ptr_q;

  // Round-robin start pointer moves just past each winner; a round with no hit leaves it alone.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      start_ptr_q <= '0;
    end else if (en_net && scan && hit) begin
      start_ptr_q <= nextPtr;
    end
  end
`endif

  // A round may start once every participating lane requests; lanes beyond active_neuron are don't-care.
  always_comb begin
    reqAll = 1'b1;
    for (int i = 0; i < NUM_NEURON; i++) begin
      if ((i < int'(active_neuron)) && !en_network[i]) begin
        reqAll = 1'b0;
      end
    end
  end

  // Next-state logic and the scanner control strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    scan    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active_neuron != '0) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (active_neuron == '0) begin
          state_d = ST_IDLE;
        end else if (reqAll) begin
          load    = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan = 1'b1;
        if (hit || exhausted) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  spike_rr_scan #(
    .TEN_DATA_WIDTH (TEN_DATA_WIDTH),
    .NEURON_ID_WIDTH(NEURON_ID_WIDTH),
    .NUM_NEURON     (NUM_NEURON)
  ) uScan (
    .clk        (clk),
    .reset_l    (reset_l),
    .en_i       (en_net),
    .load_i     (load),
    .scan_i     (scan),
    .start_ptr_i(startSel),
    .active_i   (active_neuron),
    .snap_i     (snap_q),
    .hit_o      (hit),
    .exhausted_o(exhausted),
    .illegal_o  (illegal),
    .win_id_o   (winId),
    .next_ptr_o (nextPtr),
    .win_code_o (winCode)
  );

  // State, snapshot and registered outputs; everything freezes while en_net is low.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= ST_IDLE;
      snap_q        <= '0;
      spike_in_q    <= '0;
      networkDone_q <= 1'b0;
      spike_err_q   <= 1'b0;
    end else if (en_net) begin
      state_q       <= state_d;
      networkDone_q <= (state_d == ST_DONE);
      if (load) begin
        snap_q <= spike_out;
      end
      if (scan && hit) begin
        spike_in_q <= {winCode, winId};
      end else if (scan && exhausted) begin
        spike_in_q <= '0;
      end
      if (illegal) begin
        spike_err_q <= 1'b1;
      end
    end
  end

  assign spike_in    = spike_in_q;
  assign networkDone = networkDone_q;
  assign spike_err   = spike_err_q;

endmodule
